// File: rtl/led_scan_driver_pkg.sv
// Shared types and constants for the LED scan driver.
package display_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } state_e;

   localparam int NUM_DIGITS = 4;

   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam logic [3:0] AN3    = 4'b0111;
   localparam logic [3:0] AN2    = 4'b1011;
   localparam logic [3:0] AN1    = 4'b1101;
   localparam logic [3:0] AN0    = 4'b1110;

   function automatic logic [3:0] an_sel(input logic [1:0] idx);
      logic [3:0] r;
      r = AN_OFF;
      case (idx)
         2'd3: r = AN3;
         2'd2: r = AN2;
         2'd1: r = AN1;
         2'd0: r = AN0;
         default: r = AN_OFF;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] nib(input logic [15:0] m,
                                      input logic [1:0]  idx);
      return m[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/led_scan_driver_scan_timer.sv
// Slot counter and digit index for the LED scan driver.
// Strobes describe what the upcoming clock edge does.
module scan_timer #(
   parameter int DIGIT_CYCLES = 16,
   parameter int BLANK_CYCLES = 2,
   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1
) (
   input  logic       clk,
   input  logic       reset,
   output logic [1:0] idx_nxt_o,
   output logic       slot_start_o,
   output logic       drive_en_o,
   output logic       frame_wrap_o
);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic          wrap;

   always_comb begin
      wrap  = (cnt_q == CW'(DIGIT_CYCLES - 1));
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = wrap ? idx_q - 2'd1 : idx_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         idx_q <= 2'd3;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
      end
   end

   assign idx_nxt_o    = idx_d;
   assign slot_start_o = wrap;
   assign drive_en_o   = (cnt_d == CW'(BLANK_CYCLES));
   assign frame_wrap_o = wrap && (idx_q == 2'd0);

endmodule

// File: rtl/led_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with frame-aligned
// message update via load/ack handshake.
module led_scan_driver
   import display_pkg::*;
#(
   parameter int DIGIT_CYCLES = 16,
   parameter int BLANK_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] msg_in,
   input  logic        msg_load,
   output logic        msg_ack,
   output logic [3:0]  char,
   output logic [3:0]  an,
   output logic        frame_done
);

   logic [1:0] idx_nxt;
   logic       slot_start;
   logic       drive_en;
   logic       frame_wrap;

   scan_timer #(
      .DIGIT_CYCLES(DIGIT_CYCLES),
      .BLANK_CYCLES(BLANK_CYCLES)
   ) u_timer (
      .clk         (clk),
      .reset       (reset),
      .idx_nxt_o   (idx_nxt),
      .slot_start_o(slot_start),
      .drive_en_o  (drive_en),
      .frame_wrap_o(frame_wrap)
   );

   state_e      state_q, state_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] shadow_q, shadow_d;
   logic        pend_q, pend_d;
   logic        ack_q, ack_d;
   logic        fd_q, fd_d;
   logic [3:0]  char_q, char_d;
   logic [3:0]  an_q, an_d;

   always_comb begin
      state_d = state_q;
      if (drive_en)
         state_d = DRIVE;
      else if (slot_start)
         state_d = BLANK;
   end

   // Old shadow commits before a same-edge load overwrites it.
   always_comb begin
      disp_d   = disp_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      ack_d    = 1'b0;
      fd_d     = frame_wrap;
      if (frame_wrap && pend_q) begin
         disp_d = shadow_q;
         pend_d = 1'b0;
         ack_d  = 1'b1;
      end
      if (msg_load) begin
         shadow_d = msg_in;
         pend_d   = 1'b1;
      end
   end

   always_comb begin
      char_d = char_q;
      if (slot_start)
         char_d = nib(disp_d, idx_nxt);
      an_d = (state_d == DRIVE) ? an_sel(idx_nxt) : AN_OFF;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= BLANK;
         disp_q   <= 16'h0000;
         shadow_q <= 16'h0000;
         pend_q   <= 1'b0;
         ack_q    <= 1'b0;
         fd_q     <= 1'b0;
         char_q   <= 4'h0;
         an_q     <= AN_OFF;
      end else begin
         state_q  <= state_d;
         disp_q   <= disp_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         ack_q    <= ack_d;
         fd_q     <= fd_d;
         char_q   <= char_d;
         an_q     <= an_d;
      end
   end

   assign msg_ack    = ack_q;
   assign frame_done = fd_q;
   assign char       = char_q;
   assign an         = an_q;

endmodule
